dpi_send_arbiter: RTL and testbench
===================================

# dpi_send_arbiter

Round-robin arbiter and retry sequencer that shares one DPI send channel (the 64-bit `dpi_cpu_client_send_data` path) between N CPU-side producers. It captures one granted word into a holding register, presents it to the DPI caller, and on rejection re-presents the same word after a programmable back-off. It also keeps send/retry statistics. It sits between the `cpu` instances and the single DPI client call site in the testbench top.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..16).
- `DATA_W`, 64: payload width.
- `BACKOFF`, 2: idle cycles between a rejected attempt and its retry (0..255).

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_vld`  in  N_REQ  per-requester valid.
- `req_data`  in  N_REQ×DATA_W  per-requester payload, packed, requester i at bits [i*DATA_W +: DATA_W].
- `req_rdy`  out  N_REQ  one-hot-or-zero accept; a word transfers when `req_vld[i] && req_rdy[i]`.
- `out_vld`  out  1  the held word is being offered to DPI this cycle.
- `out_data`  out  DATA_W  held word.
- `out_src`  out  $clog2(N_REQ)  index of the requester that owns the held word.
- `out_accept`  in  1  DPI result for this cycle's offer; 1 = consumed, 0 = rejected. Only meaningful while `out_vld`.
- `busy`  out  1  state ≠ IDLE.
- `sent_cnt`  out  32  words accepted by DPI since reset, wraps at 2^32.
- `retry_cnt`  out  16  rejected offers since reset, saturates at 0xFFFF.

## Operation
- FSM states: IDLE, SEND, BACKOFF.
- IDLE:
  - If any `req_vld`, grant the first valid requester at or after `rr_ptr` (circular search).
  - Assert `req_rdy` for the granted requester only.
  - Capture its data and index into the holding register and go to SEND.
- SEND: `out_vld`=1.
  - `out_accept`=1: `sent_cnt`+1.
    - If any `req_vld`, grant and capture the next requester in the same cycle (back-to-back) and stay in SEND.
    - Otherwise go to IDLE.
  - `out_accept`=0: `retry_cnt`+1 (saturating).
    - `BACKOFF`=0: stay in SEND and re-offer next cycle.
    - `BACKOFF`>0: load the back-off counter with `BACKOFF` and go to BACKOFF.
- BACKOFF: `out_vld`=0. Decrement the counter; when it reaches 1, go to SEND. The holding register is unchanged.
- `rr_ptr` updates to (granted index + 1) mod N_REQ on every grant. It resets to 0.
- `req_rdy[i]` = grant[i] && (state==IDLE || (state==SEND && out_accept)). This is combinational from `req_vld`, `out_accept` and state.
- No word is ever dropped or duplicated. The held word is stable from capture until the DPI accepts it.

## Timing
- Reset values: `req_rdy`=0, `out_vld`=0, `out_data`=0, `out_src`=0, `busy`=0, `sent_cnt`=0, `retry_cnt`=0; state IDLE.
- Latency: `req_vld` in IDLE at cycle 0 → `out_vld` with that data at cycle 1.
- Peak throughput: 1 word/cycle while DPI accepts and requests are pending.
- Reject timing: a reject at cycle t re-offers at t+1+BACKOFF.
- Simultaneous requests: strict round-robin from `rr_ptr`. A requester waits at most N_REQ−1 grants.
- `req_vld` dropping while not granted is legal and is ignored.
- `out_accept` while `out_vld`=0 is ignored.
- `rst_n` asserted mid-SEND or mid-BACKOFF:
  - The held word is discarded, all outputs return to reset values immediately (asynchronous), and counters clear.
  - The first grant after release is to the lowest valid index.

## Structure
- Shared package `dpi_arb_pkg`:
  - state enum `dpi_arb_state_e` (IDLE/SEND/BACKOFF).
  - `DPI_DATA_W`=64.
  - `CNT_W`=32 and `RETRY_W`=16.
- Sub-module `rr_picker` (`N_REQ`): inputs `req`, `ptr`; outputs `grant` one-hot, `grant_idx`, `any`. It is purely combinational and reused by other arbiters.
- Top contains the FSM, holding register, back-off counter and statistics counters.

## Test plan
- Single request, always accept, N_REQ=4: `req_vld`=0001, data 0xDEAD_BEEF → `req_rdy[0]` in cycle 0; `out_vld` with 0xDEAD_BEEF and `out_src`=0 in cycle 1; `sent_cnt`=1; back to IDLE in cycle 2.
- All four requesters valid continuously, always accept → grant order 0,1,2,3,0,…; one word per cycle; after 8 accepts `sent_cnt`=8.
- Reject path, BACKOFF=2: offer 0x1234 and drive `out_accept`=0 twice, then 1 → offers at cycles 1, 4 and 7, all carrying 0x1234; `retry_cnt`=2; `sent_cnt`=1; no `req_rdy` during the retries.
- BACKOFF=0 with a reject → `out_vld` stays high and the same data is re-offered on the next cycle.
- Reset asserted during BACKOFF → all outputs at reset values within the same cycle. After release with `req_vld`=1010, the first grant goes to requester 1.
- `retry_cnt` saturation: force 65 540 consecutive rejects → `retry_cnt` holds 0xFFFF and the held data is unchanged.

Source files
------------

// File: rtl/dpi_arb_pkg.sv
// Shared types and widths for the DPI send-channel arbiter.
// Also includes the FSM state encoding.
package dpi_arb_pkg;
  localparam int DPI_DATA_W = 64;
  localparam int CNT_W      = 32;
  localparam int RETRY_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_BACKOFF
  } dpi_arb_state_e;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of req at or after ptr, searching circularly.
module rr_picker #(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             any
);
  int   idx;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = |req;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/dpi_send_arbiter.sv
// Shares one DPI send channel between N_REQ producers: round-robin grant into a holding
// register, re-offer on reject after BACKOFF idle cycles, plus send/retry statistics.
module dpi_send_arbiter
  import dpi_arb_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int DATA_W  = DPI_DATA_W,
  parameter  int BACKOFF = 2,
  localparam int IW      = $clog2(N_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_vld,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]              req_rdy,
  output logic                          out_vld,
  output logic [DATA_W-1:0]             out_data,
  output logic [IW-1:0]                 out_src,
  input  logic                          out_accept,
  output logic                          busy,
  output logic [CNT_W-1:0]              sent_cnt,
  output logic [RETRY_W-1:0]            retry_cnt
);
  dpi_arb_state_e      state_q, state_d;
  logic [DATA_W-1:0]   hold_data_q, hold_data_d;
  logic [IW-1:0]       hold_src_q, hold_src_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [7:0]          bo_cnt_q, bo_cnt_d;
  logic [CNT_W-1:0]    sent_cnt_q, sent_cnt_d;
  logic [RETRY_W-1:0]  retry_cnt_q, retry_cnt_d;

  logic [N_REQ-1:0]    grant;
  logic [IW-1:0]       grant_idx;
  logic                any;
  logic                take;

  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req       (req_vld),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_src_d  = hold_src_q;
    rr_ptr_d    = rr_ptr_q;
    bo_cnt_d    = bo_cnt_q;
    sent_cnt_d  = sent_cnt_q;
    retry_cnt_d = retry_cnt_q;
    take        = 1'b0;
    case (state_q)
      ST_IDLE: take = any;
      ST_SEND: begin
        if (out_accept) begin
          sent_cnt_d = sent_cnt_q + CNT_W'(1);
          take       = any;
          if (!any) state_d = ST_IDLE;
        end else begin
          if (retry_cnt_q != '1) retry_cnt_d = retry_cnt_q + RETRY_W'(1);
          if (BACKOFF != 0) begin
            bo_cnt_d = 8'(BACKOFF);
            state_d  = ST_BACKOFF;
          end
        end
      end
      ST_BACKOFF: begin
        // Leaving on a count of 1 makes the retry land exactly BACKOFF idle cycles later.
        if (bo_cnt_q <= 8'd1) state_d = ST_SEND;
        else                  bo_cnt_d = bo_cnt_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (take) begin
      hold_data_d = req_data[grant_idx];
      hold_src_d  = grant_idx;
      rr_ptr_d    = (grant_idx == IW'(N_REQ-1)) ? '0 : grant_idx + IW'(1);
      state_d     = ST_SEND;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_data_q <= '0;
      hold_src_q  <= '0;
      rr_ptr_q    <= '0;
      bo_cnt_q    <= '0;
      sent_cnt_q  <= '0;
      retry_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_src_q  <= hold_src_d;
      rr_ptr_q    <= rr_ptr_d;
      bo_cnt_q    <= bo_cnt_d;
      sent_cnt_q  <= sent_cnt_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  assign req_rdy   = take ? grant : '0;
  assign out_vld   = (state_q == ST_SEND);
  assign out_data  = hold_data_q;
  assign out_src   = hold_src_q;
  assign busy      = (state_q != ST_IDLE);
  assign sent_cnt  = sent_cnt_q;
  assign retry_cnt = retry_cnt_q;
endmodule

// File: tb/tb_dpi_send_arbiter.sv
// Directed bench for dpi_send_arbiter: one instance with BACKOFF=2, one with BACKOFF=0.
module tb_dpi_send_arbiter;
  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0][63:0] req_data;
  logic [3:0]       req_vld, req_rdy, req_vld0, rdy0;
  logic             acc, acc0, ov, ov0, busy, busy0;
  logic [63:0]      od, od0;
  logic [1:0]       os, os0;
  logic [31:0]      sent, sent0;
  logic [15:0]      retry, retry0;

  typedef struct packed { logic [63:0] data; logic [1:0] src; } exp_t;
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  dpi_send_arbiter #(.N_REQ(4), .DATA_W(64), .BACKOFF(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_data(req_data), .req_rdy(req_rdy),
    .out_vld(ov), .out_data(od), .out_src(os), .out_accept(acc), .busy(busy),
    .sent_cnt(sent), .retry_cnt(retry));

  dpi_send_arbiter #(.N_REQ(4), .DATA_W(64), .BACKOFF(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld0), .req_data(req_data), .req_rdy(rdy0),
    .out_vld(ov0), .out_data(od0), .out_src(os0), .out_accept(acc0), .busy(busy0),
    .sent_cnt(sent0), .retry_cnt(retry0));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s observed=offer expected=empty_scoreboard", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"}, od, e.data);
      chk({tag, "_src"}, 64'(os), 64'(e.src));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_vld = '0; acc = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req_vld = '0; req_vld0 = '0; acc = 1'b0; acc0 = 1'b0; req_data = '0;
    @(negedge clk); #1;
    chk("rst_rdy", 64'(req_rdy), 0); chk("rst_vld", 64'(ov), 0);
    chk("rst_data", od, 0);          chk("rst_src", 64'(os), 0);
    chk("rst_busy", 64'(busy), 0);   chk("rst_sent", 64'(sent), 0);
    chk("rst_retry", 64'(retry), 0);
    rst_n = 1'b1;

    // Single request, always accept
    @(negedge clk);
    req_vld = 4'b0001; req_data[0] = 64'hDEAD_BEEF; acc = 1'b1;
    sb.push_back('{64'hDEAD_BEEF, 2'd0});
    #1 chk("t1_rdy", 64'(req_rdy), 64'h1); chk("t1_vld0", 64'(ov), 0);
    @(negedge clk);
    req_vld = '0;
    #1 chk("t1_vld1", 64'(ov), 1); chk_pop("t1_word"); chk("t1_rdy1", 64'(req_rdy), 0);
    @(negedge clk); #1;
    chk("t1_idle", 64'(busy), 0); chk("t1_vld2", 64'(ov), 0); chk("t1_sent", 64'(sent), 1);

    // All four valid, back-to-back round robin
    do_reset();
    #1 chk("rst2_sent", 64'(sent), 0);
    @(negedge clk);
    req_vld = 4'hF; acc = 1'b1;
    for (int i = 0; i < 4; i++) req_data[i] = 64'h1000 + 64'(i);
    for (int k = 0; k < 8; k++) sb.push_back('{64'h1000 + 64'(k % 4), 2'(k % 4)});
    #1 chk("rr_rdy0", 64'(req_rdy), 64'h1);
    for (int k = 1; k <= 8; k++) begin
      logic [3:0] er;
      @(negedge clk);
      if (k == 8) req_vld = '0;
      er = (k == 8) ? 4'h0 : 4'(1 << (k % 4));
      #1 chk("rr_vld", 64'(ov), 1); chk_pop("rr_word"); chk("rr_rdy", 64'(req_rdy), 64'(er));
    end
    @(negedge clk); #1;
    chk("rr_vld_end", 64'(ov), 0); chk("rr_sent", 64'(sent), 8);

    // Reject path with BACKOFF=2: offers at cycles 1, 4, 7
    do_reset();
    @(negedge clk);
    req_vld = 4'b0001; req_data[0] = 64'h1234; acc = 1'b0;
    sb.push_back('{64'h1234, 2'd0});
    #1 chk("rj_rdy0", 64'(req_rdy), 64'h1);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      req_vld = (c < 7) ? 4'b0010 : 4'b0000;
      acc = (c == 7);
      #1;
      chk("rj_vld", 64'(ov), 64'(c == 1 || c == 4 || c == 7));
      chk("rj_hold", od, 64'h1234);
      chk("rj_rdy", 64'(req_rdy), 0);
      chk("rj_busy", 64'(busy), 1);
      if (c == 7) chk_pop("rj_word");
    end
    @(negedge clk); #1;
    chk("rj_vld_end", 64'(ov), 0); chk("rj_sent", 64'(sent), 1); chk("rj_retry", 64'(retry), 2);

    // Async reset in BACKOFF, then first grant goes to lowest valid index
    @(negedge clk);
    req_vld = 4'b0001; req_data[0] = 64'h5555; acc = 1'b0;
    #1 chk("ar_rdy0", 64'(req_rdy), 64'h1);
    @(negedge clk);
    req_vld = '0;
    #1 chk("ar_vld1", 64'(ov), 1);
    @(negedge clk); #1;
    chk("ar_bo_busy", 64'(busy), 1); chk("ar_bo_vld", 64'(ov), 0);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_busy", 64'(busy), 0);   chk("ar_vld", 64'(ov), 0);
    chk("ar_data", od, 0);          chk("ar_src", 64'(os), 0);
    chk("ar_sent", 64'(sent), 0);   chk("ar_retry", 64'(retry), 0);
    chk("ar_rdy", 64'(req_rdy), 0);
    @(negedge clk);
    rst_n = 1'b1; req_vld = 4'b1010; req_data[1] = 64'h7777; req_data[3] = 64'h9999; acc = 1'b1;
    sb.push_back('{64'h7777, 2'd1});
    #1 chk("ar_first_grant", 64'(req_rdy), 64'h2);
    @(negedge clk);
    req_vld = '0;
    #1 chk("ar_vld2", 64'(ov), 1); chk_pop("ar_word");
    @(negedge clk); #1 chk("ar_sent2", 64'(sent), 1);

    // BACKOFF=0: immediate re-offer, then retry counter saturation
    @(negedge clk);
    req_vld0 = 4'b0001; req_data[0] = 64'hABCD; acc0 = 1'b0;
    #1 chk("b0_rdy", 64'(rdy0), 64'h1);
    @(negedge clk);
    req_vld0 = '0;
    #1 chk("b0_vld1", 64'(ov0), 1); chk("b0_data1", od0, 64'hABCD);
    @(negedge clk); #1;
    chk("b0_vld2", 64'(ov0), 1); chk("b0_data2", od0, 64'hABCD); chk("b0_retry1", 64'(retry0), 1);
    repeat (65538) @(negedge clk);
    @(negedge clk);
    acc0 = 1'b1;
    #1;
    chk("sat_retry", 64'(retry0), 64'hFFFF); chk("sat_data", od0, 64'hABCD);
    chk("sat_vld", 64'(ov0), 1);             chk("sat_src", 64'(os0), 0);
    @(negedge clk);
    acc0 = 1'b0;
    #1;
    chk("sat_sent", 64'(sent0), 1); chk("sat_vld_end", 64'(ov0), 0);
    chk("sat_retry_hold", 64'(retry0), 64'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
